// File: rtl/instr_mem_if.sv
// rtl/instr_mem_if.sv - fetch and program-loader signal bundle for instr_mem
//
// Purpose: groups the fetch read port and the program-loader handshake.
// master: fetch stage / host side (drives requests and load words)
// slave : instr_mem side (returns read data and loader status)
// Signals:
//   im_addr_i, im_rd_i               fetch address and read strobe
//   im_data_o, im_valid_o, im_perr_o registered read data, valid, parity error
//   load_start_i, load_valid_i, load_data_i, load_last_i, load_flip_par_i
//                                    loader control and word stream
//   load_ready_o, load_done_o, load_full_o, load_count_o
//                                    loader status
interface instr_mem_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] im_addr_i;
  logic                  im_rd_i;
  logic [DATA_WIDTH-1:0] im_data_o;
  logic                  im_valid_o;
  logic                  im_perr_o;

  logic                  load_start_i;
  logic                  load_valid_i;
  logic [DATA_WIDTH-1:0] load_data_i;
  logic                  load_last_i;
  logic                  load_flip_par_i;
  logic                  load_ready_o;
  logic                  load_done_o;
  logic                  load_full_o;
  logic [ADDR_WIDTH:0]   load_count_o;

  modport master (
    output im_addr_i, im_rd_i,
    output load_start_i, load_valid_i, load_data_i, load_last_i, load_flip_par_i,
    input  im_data_o, im_valid_o, im_perr_o,
    input  load_ready_o, load_done_o, load_full_o, load_count_o
  );

  modport slave (
    input  im_addr_i, im_rd_i,
    input  load_start_i, load_valid_i, load_data_i, load_last_i, load_flip_par_i,
    output im_data_o, im_valid_o, im_perr_o,
    output load_ready_o, load_done_o, load_full_o, load_count_o
  );
endinterface

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - instruction memory with 1-cycle read port and sequential program loader
//
// Purpose: serves fetch reads with registered one-cycle latency and fills the
// array word by word through a valid/ready loader FSM (IDLE -> LOAD -> DONE).
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset (memory contents are kept)
//   bus  instr_mem_if.slave: fetch port and loader handshake/status
// Optional feature: define IM_PARITY_EN to store an even-parity bit per word
// and report mismatches on im_perr_o; otherwise im_perr_o is tied to 0.
module instr_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  instr_mem_if.slave bus
);

`ifdef IM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [MEM_W-1:0]      mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  accept;
  logic                  at_top;
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;

  assign accept  = (state_q == LOAD) && bus.load_valid_i;
  assign at_top  = (wr_ptr_q == LAST_ADDR);
  assign rd_word = mem[bus.im_addr_i];

`ifdef IM_PARITY_EN
  // Stored bit makes the whole entry XOR to 0; the flip input plants errors.
  assign wr_word = {(^bus.load_data_i) ^ bus.load_flip_par_i, bus.load_data_i};
`else
  logic unused_flip;
  assign unused_flip = bus.load_flip_par_i;
  assign wr_word     = bus.load_data_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.load_start_i) state_d = LOAD;
      LOAD: if (accept && (bus.load_last_i || at_top)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.load_ready_o = (state_q == LOAD);
  assign bus.load_done_o  = (state_q == DONE);
  assign bus.load_full_o  = full_q;
  assign bus.load_count_o = count_q;

  // Loader pointer, count and full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else if (state_q == IDLE && bus.load_start_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else if (accept) begin
      // Pointer wraps after the top word, but the FSM leaves LOAD on that same edge.
      wr_ptr_q <= wr_ptr_q + PTR_ONE;
      count_q  <= count_q + CNT_ONE;
      if (at_top && !bus.load_last_i) full_q <= 1'b1;
    end
  end

  // Array write; no reset so contents survive rst. A write in the rst cycle is dropped.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_ptr_q] <= wr_word;
  end

  // Read port: blocked while loading, so reads never collide with writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state_q == LOAD) begin
      rd_valid_q <= 1'b0;
      if (bus.im_rd_i) rd_data_q <= '0;
    end else if (bus.im_rd_i) begin
      rd_data_q  <= rd_word[DATA_WIDTH-1:0];
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.im_data_o  = rd_data_q;
  assign bus.im_valid_o = rd_valid_q;

`ifdef IM_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst)                                   perr_q <= 1'b0;
    else if (state_q != LOAD && bus.im_rd_i)   perr_q <= ^rd_word;
    else                                       perr_q <= 1'b0;
  end

  assign bus.im_perr_o = perr_q;
`else
  assign bus.im_perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - directed self-checking bench for instr_mem
module tb_instr_mem;
  localparam int DW = 16;
  localparam int AW = 8;

`ifdef IM_PARITY_EN
  localparam logic PERR_FLIPPED = 1'b1;
`else
  localparam logic PERR_FLIPPED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one word for a single cycle; returns at the negedge after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic flip);
    bus.load_valid_i    = 1'b1;
    bus.load_data_i     = d;
    bus.load_last_i     = last;
    bus.load_flip_par_i = flip;
    step();
    bus.load_valid_i    = 1'b0;
    bus.load_last_i     = 1'b0;
    bus.load_flip_par_i = 1'b0;
  endtask

  task automatic start_load();
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                      input logic exp_perr, input string tag);
    bus.im_rd_i   = 1'b1;
    bus.im_addr_i = a;
    step();
    bus.im_rd_i   = 1'b0;
    check({tag, "_data"},  32'(bus.im_data_o),  32'(exp_d));
    check({tag, "_valid"}, 32'(bus.im_valid_o), 32'd1);
    check({tag, "_perr"},  32'(bus.im_perr_o),  32'(exp_perr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    bus.im_addr_i       = '0;
    bus.im_rd_i         = 1'b0;
    bus.load_start_i    = 1'b0;
    bus.load_valid_i    = 1'b0;
    bus.load_data_i     = '0;
    bus.load_last_i     = 1'b0;
    bus.load_flip_par_i = 1'b0;

    // Reset state
    step();
    step();
    check("rst_data",  32'(bus.im_data_o),    32'd0);
    check("rst_valid", 32'(bus.im_valid_o),   32'd0);
    check("rst_perr",  32'(bus.im_perr_o),    32'd0);
    check("rst_done",  32'(bus.load_done_o),  32'd0);
    check("rst_full",  32'(bus.load_full_o),  32'd0);
    check("rst_count", 32'(bus.load_count_o), 32'd0);
    check("rst_ready", 32'(bus.load_ready_o), 32'd0);
    rst = 1'b0;

    // 4-word load with valid gaps, then back-to-back reads
    start_load();
    check("t1_ready", 32'(bus.load_ready_o), 32'd1);
    check("t1_count0", 32'(bus.load_count_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step();
      send(words[i], (i == 3), 1'b0);
      check($sformatf("t1_count%0d", i + 1), 32'(bus.load_count_o), 32'(i + 1));
      check($sformatf("t1_done%0d", i + 1), 32'(bus.load_done_o), (i == 3) ? 32'd1 : 32'd0);
    end
    check("t1_full",   32'(bus.load_full_o),  32'd0);
    check("t1_rdy_dn", 32'(bus.load_ready_o), 32'd0);
    step();
    check("t1_done_pulse", 32'(bus.load_done_o), 32'd0);
    bus.im_rd_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.im_addr_i = AW'(i);
      step();
      check($sformatf("t1_rd%0d_data", i),  32'(bus.im_data_o),  32'(words[i]));
      check($sformatf("t1_rd%0d_valid", i), 32'(bus.im_valid_o), 32'd1);
    end
    bus.im_rd_i = 1'b0;
    step();
    check("t1_idle_valid", 32'(bus.im_valid_o), 32'd0);
    check("t1_hold_data",  32'(bus.im_data_o),  32'h4444);

    // Full-depth load without load_last_i
    start_load();
    for (int i = 0; i < 256; i++) begin
      send(DW'(i), 1'b0, 1'b0);
      if (i == 254) begin
        check("t2_cnt255",  32'(bus.load_count_o), 32'd255);
        check("t2_done255", 32'(bus.load_done_o),  32'd0);
        check("t2_rdy255",  32'(bus.load_ready_o), 32'd1);
      end
    end
    check("t2_done",  32'(bus.load_done_o),  32'd1);
    check("t2_full",  32'(bus.load_full_o),  32'd1);
    check("t2_count", 32'(bus.load_count_o), 32'd256);
    step();
    check("t2_full_sticky", 32'(bus.load_full_o), 32'd1);
    read(8'd255, 16'h00FF, 1'b0, "t2_rd255");
    read(8'd0,   16'h0000, 1'b0, "t2_rd0");

    // Reset mid-load, and reset together with load_start_i
    start_load();
    check("t3_full_clr", 32'(bus.load_full_o), 32'd0);
    send(16'hA0A0, 1'b0, 1'b0);
    send(16'hB1B1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("t3_ready", 32'(bus.load_ready_o), 32'd0);
    check("t3_done",  32'(bus.load_done_o),  32'd0);
    check("t3_count", 32'(bus.load_count_o), 32'd0);
    check("t3_full",  32'(bus.load_full_o),  32'd0);
    check("t3_valid", 32'(bus.im_valid_o),   32'd0);
    check("t3_data",  32'(bus.im_data_o),    32'd0);
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
    rst = 1'b0;
    check("t3_rst_wins", 32'(bus.load_ready_o), 32'd0);
    step();
    check("t3_still_idle", 32'(bus.load_ready_o), 32'd0);
    check("t3_no_done",    32'(bus.load_done_o),  32'd0);
    read(8'd1, 16'hB1B1, 1'b0, "t3_rd1");
    read(8'd0, 16'hA0A0, 1'b0, "t3_rd0");

    // Read during LOAD blocked; start during LOAD ignored
    start_load();
    send(16'h5555, 1'b0, 1'b0);
    bus.im_rd_i   = 1'b1;
    bus.im_addr_i = 8'd2;
    step();
    bus.im_rd_i = 1'b0;
    check("t4_ld_valid", 32'(bus.im_valid_o), 32'd0);
    check("t4_ld_data",  32'(bus.im_data_o),  32'd0);
    start_load();
    check("t4_ready", 32'(bus.load_ready_o), 32'd1);
    check("t4_count", 32'(bus.load_count_o), 32'd1);
    send(16'h6666, 1'b1, 1'b0);
    check("t4_done",   32'(bus.load_done_o),  32'd1);
    check("t4_count2", 32'(bus.load_count_o), 32'd2);
    step();
    read(8'd1, 16'h6666, 1'b0, "t4_rd1");
    read(8'd0, 16'h5555, 1'b0, "t4_rd0");

    // Parity: second word stored with an inverted parity bit
    start_load();
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0003, 1'b1, 1'b1);
    check("t5_done", 32'(bus.load_done_o), 32'd1);
    step();
    read(8'd0, 16'h0001, 1'b0,         "t5_rd0");
    read(8'd1, 16'h0003, PERR_FLIPPED, "t5_rd1");
    step();
    check("t5_perr_idle",  32'(bus.im_perr_o),  32'd0);
    check("t5_valid_idle", 32'(bus.im_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
